// File: rtl/cycle_timer_if.sv
// Controller <-> cycle timer signal bundle.
// master: washer controller side, slave: cycle_timer side.
interface cycle_timer_if;
    logic [1:0] program_Select;
    logic       load_Program;
    logic       fill_Water_Operation;
    logic       heat_Water_Operation;
    logic       wash_Operation;
    logic       rinse_Operation;
    logic       spin_Operation;
    logic       fault;
    logic       sig_Lid_Closed;
    logic       sig_Time_Out;
    logic       sig_Wash_Completed;
    logic       sig_Rinse_Completed;
    logic       sig_Spin_Completed;
    logic       paused;
    logic       phase_Error;
    logic [7:0] remaining;
    logic [2:0] phase;

    modport master (
        output program_Select, load_Program,
        output fill_Water_Operation, heat_Water_Operation,
        output wash_Operation, rinse_Operation, spin_Operation,
        output fault, sig_Lid_Closed,
        input  sig_Time_Out, sig_Wash_Completed,
        input  sig_Rinse_Completed, sig_Spin_Completed,
        input  paused, phase_Error, remaining, phase
    );

    modport slave (
        input  program_Select, load_Program,
        input  fill_Water_Operation, heat_Water_Operation,
        input  wash_Operation, rinse_Operation, spin_Operation,
        input  fault, sig_Lid_Closed,
        output sig_Time_Out, sig_Wash_Completed,
        output sig_Rinse_Completed, sig_Spin_Completed,
        output paused, phase_Error, remaining, phase
    );
endinterface

// File: rtl/cycle_timer.sv
// Washer phase timer: prescaled tick countdown per controller phase.
// Ports: clock, reset (sync, active-high), bus (cycle_timer_if.slave).
module cycle_timer #(
    parameter int unsigned TICK_DIV   = 1000,
    parameter logic [7:0]  FILL_LIMIT = 8'd60,
    parameter logic [7:0]  HEAT_LIMIT = 8'd90
) (
    input  logic          clock,
    input  logic          reset,
    cycle_timer_if.slave  bus
);

    typedef enum logic [2:0] {
        PH_NONE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_HEAT  = 3'd2,
        PH_WASH  = 3'd3,
        PH_RINSE = 3'd4,
        PH_SPIN  = 3'd5
    } phase_e;

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    phase_e      phase_q, phase_d, dec_phase;
    logic [7:0]  rem_q, rem_d;
    logic [15:0] presc_q, presc_d;
    logic [1:0]  prog_q, prog_d;
    logic        err_q, err_d;
    logic [4:0]  ops;
    logic        one_hot, multi, hold, tick;

    function automatic logic [7:0] duration(
        input phase_e p,
        input logic [1:0] pg
    );
        logic [7:0] d;
        d = 8'd0;
        case (p)
            PH_FILL: d = FILL_LIMIT;
            PH_HEAT: d = HEAT_LIMIT;
            PH_WASH: begin
                case (pg)
                    2'd0: d = 8'd40;
                    2'd1: d = 8'd20;
                    2'd2: d = 8'd60;
                    default: d = 8'd30;
                endcase
            end
            PH_RINSE: begin
                case (pg)
                    2'd0: d = 8'd20;
                    2'd1: d = 8'd10;
                    2'd2: d = 8'd30;
                    default: d = 8'd20;
                endcase
            end
            PH_SPIN: begin
                case (pg)
                    2'd0: d = 8'd15;
                    2'd1: d = 8'd8;
                    2'd2: d = 8'd25;
                    default: d = 8'd5;
                endcase
            end
            default: d = 8'd0;
        endcase
        return d;
    endfunction

    always_comb begin
        ops = {bus.spin_Operation, bus.rinse_Operation,
               bus.wash_Operation, bus.heat_Water_Operation,
               bus.fill_Water_Operation};
        // x & (x-1) clears the lowest set bit: nonzero means 2+ bits set
        multi   = (ops & (ops - 5'd1)) != 5'd0;
        one_hot = (ops != 5'd0) && !multi;
        dec_phase = PH_NONE;
        if (one_hot && !bus.fault) begin
            unique case (1'b1)
                ops[0]: dec_phase = PH_FILL;
                ops[1]: dec_phase = PH_HEAT;
                ops[2]: dec_phase = PH_WASH;
                ops[3]: dec_phase = PH_RINSE;
                ops[4]: dec_phase = PH_SPIN;
                default: dec_phase = PH_NONE;
            endcase
        end
    end

    // Open lid freezes only the timed mechanical phases
    assign hold = (phase_q == PH_WASH || phase_q == PH_RINSE ||
                   phase_q == PH_SPIN) && !bus.sig_Lid_Closed;
    assign tick = presc_q == PRESC_MAX;

    always_comb begin
        phase_d = phase_q;
        rem_d   = rem_q;
        presc_d = presc_q;
        err_d   = err_q | multi;
        // Program latched before the duration lookup so a coincident
        // phase entry uses the newly loaded program
        prog_d  = (bus.load_Program && phase_q == PH_NONE)
                  ? bus.program_Select : prog_q;
        if (dec_phase != phase_q) begin
            phase_d = dec_phase;
            rem_d   = duration(dec_phase, prog_d);
            presc_d = 16'd0;
        end else if (!hold) begin
            if (tick) begin
                presc_d = 16'd0;
                if (rem_q != 8'd0)
                    rem_d = rem_q - 8'd1;
            end else begin
                presc_d = presc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q <= PH_NONE;
            rem_q   <= 8'd0;
            presc_q <= 16'd0;
            prog_q  <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            rem_q   <= rem_d;
            presc_q <= presc_d;
            prog_q  <= prog_d;
            err_q   <= err_d;
        end
    end

    assign bus.sig_Time_Out =
        (phase_q == PH_FILL || phase_q == PH_HEAT) && rem_q == 8'd0;
    assign bus.sig_Wash_Completed  = phase_q == PH_WASH  && rem_q == 8'd0;
    assign bus.sig_Rinse_Completed = phase_q == PH_RINSE && rem_q == 8'd0;
    assign bus.sig_Spin_Completed  = phase_q == PH_SPIN  && rem_q == 8'd0;
    assign bus.paused      = hold;
    assign bus.phase_Error = err_q;
    assign bus.remaining   = rem_q;
    assign bus.phase       = phase_q;

endmodule

// File: tb/tb_cycle_timer.sv
// Directed self-checking bench for cycle_timer with TICK_DIV = 4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_cycle_timer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total  = 0;

    cycle_timer_if bus();

    cycle_timer #(.TICK_DIV(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.program_Select       = 2'd0;
        bus.load_Program         = 1'b0;
        bus.fill_Water_Operation = 1'b0;
        bus.heat_Water_Operation = 1'b0;
        bus.wash_Operation       = 1'b0;
        bus.rinse_Operation      = 1'b0;
        bus.spin_Operation       = 1'b0;
        bus.fault                = 1'b0;
        bus.sig_Lid_Closed       = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step(3);
        total++;
        if (bus.phase !== 3'd0 || bus.remaining !== 8'd0)
            $display("FAIL reset_state: phase=%0d rem=%0d want 0/0",
                     bus.phase, bus.remaining);
        else passed++;
        total++;
        if ({bus.sig_Time_Out, bus.sig_Wash_Completed,
             bus.sig_Rinse_Completed, bus.sig_Spin_Completed,
             bus.paused, bus.phase_Error} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000",
                     {bus.sig_Time_Out, bus.sig_Wash_Completed,
                      bus.sig_Rinse_Completed, bus.sig_Spin_Completed,
                      bus.paused, bus.phase_Error});
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_wash();
        do_reset();
        bus.program_Select = 2'd0;
        bus.load_Program = 1'b1;
        step(1);
        bus.load_Program = 1'b0;
        bus.wash_Operation = 1'b1;
        step(1);
        total++;
        if (bus.phase !== 3'd3 || bus.remaining !== 8'd40)
            $display("FAIL wash_load: phase=%0d rem=%0d want 3/40",
                     bus.phase, bus.remaining);
        else passed++;
        step(159);
        total++;
        if (bus.sig_Wash_Completed !== 1'b0 || bus.remaining !== 8'd1)
            $display("FAIL wash_159: done=%b rem=%0d want 0/1",
                     bus.sig_Wash_Completed, bus.remaining);
        else passed++;
        step(1);
        total++;
        if (bus.sig_Wash_Completed !== 1'b1 || bus.remaining !== 8'd0)
            $display("FAIL wash_160: done=%b rem=%0d want 1/0",
                     bus.sig_Wash_Completed, bus.remaining);
        else passed++;
        step(5);
        total++;
        if (bus.sig_Wash_Completed !== 1'b1)
            $display("FAIL wash_hold: done=%b want 1",
                     bus.sig_Wash_Completed);
        else passed++;
        bus.wash_Operation = 1'b0;
        step(1);
        total++;
        if (bus.sig_Wash_Completed !== 1'b0 || bus.phase !== 3'd0)
            $display("FAIL wash_drop: done=%b phase=%0d want 0/0",
                     bus.sig_Wash_Completed, bus.phase);
        else passed++;
    endtask

    task automatic test_fill_timeout();
        do_reset();
        bus.fill_Water_Operation = 1'b1;
        step(1);
        total++;
        if (bus.phase !== 3'd1 || bus.remaining !== 8'd60)
            $display("FAIL fill_load: phase=%0d rem=%0d want 1/60",
                     bus.phase, bus.remaining);
        else passed++;
        step(239);
        total++;
        if (bus.sig_Time_Out !== 1'b0)
            $display("FAIL fill_239: timeout=%b want 0", bus.sig_Time_Out);
        else passed++;
        step(1);
        total++;
        if (bus.sig_Time_Out !== 1'b1 || bus.remaining !== 8'd0)
            $display("FAIL fill_240: timeout=%b rem=%0d want 1/0",
                     bus.sig_Time_Out, bus.remaining);
        else passed++;
        step(8);
        total++;
        if (bus.remaining !== 8'd0 || bus.paused !== 1'b0)
            $display("FAIL fill_sat: rem=%0d paused=%b want 0/0",
                     bus.remaining, bus.paused);
        else passed++;
        bus.fill_Water_Operation = 1'b0;
        step(1);
    endtask

    task automatic test_lid_pause();
        do_reset();
        bus.program_Select = 2'd1;
        bus.load_Program = 1'b1;
        step(1);
        bus.load_Program = 1'b0;
        bus.spin_Operation = 1'b1;
        step(1);
        total++;
        if (bus.remaining !== 8'd8)
            $display("FAIL spin_load: rem=%0d want 8", bus.remaining);
        else passed++;
        step(10);
        total++;
        if (bus.remaining !== 8'd6)
            $display("FAIL spin_10: rem=%0d want 6", bus.remaining);
        else passed++;
        bus.sig_Lid_Closed = 1'b0;
        #1;
        total++;
        if (bus.paused !== 1'b1)
            $display("FAIL pause_on: paused=%b want 1", bus.paused);
        else passed++;
        step(10);
        total++;
        if (bus.paused !== 1'b1 || bus.remaining !== 8'd6)
            $display("FAIL pause_hold: paused=%b rem=%0d want 1/6",
                     bus.paused, bus.remaining);
        else passed++;
        bus.sig_Lid_Closed = 1'b1;
        step(21);
        total++;
        if (bus.sig_Spin_Completed !== 1'b0 || bus.remaining !== 8'd1)
            $display("FAIL spin_41: done=%b rem=%0d want 0/1",
                     bus.sig_Spin_Completed, bus.remaining);
        else passed++;
        step(1);
        total++;
        if (bus.sig_Spin_Completed !== 1'b1)
            $display("FAIL spin_42: done=%b want 1",
                     bus.sig_Spin_Completed);
        else passed++;
        bus.spin_Operation = 1'b0;
        step(1);
    endtask

    task automatic test_lockout();
        do_reset();
        bus.rinse_Operation = 1'b1;
        step(1);
        total++;
        if (bus.remaining !== 8'd20)
            $display("FAIL rinse_load: rem=%0d want 20", bus.remaining);
        else passed++;
        bus.program_Select = 2'd2;
        bus.load_Program = 1'b1;
        step(1);
        bus.load_Program = 1'b0;
        step(78);
        total++;
        if (bus.sig_Rinse_Completed !== 1'b0)
            $display("FAIL rinse_79: done=%b want 0",
                     bus.sig_Rinse_Completed);
        else passed++;
        step(1);
        total++;
        if (bus.sig_Rinse_Completed !== 1'b1)
            $display("FAIL rinse_80: done=%b want 1",
                     bus.sig_Rinse_Completed);
        else passed++;
        bus.rinse_Operation = 1'b0;
        step(1);
    endtask

    task automatic test_load_with_entry();
        do_reset();
        bus.program_Select = 2'd3;
        bus.load_Program = 1'b1;
        bus.wash_Operation = 1'b1;
        step(1);
        bus.load_Program = 1'b0;
        total++;
        if (bus.phase !== 3'd3 || bus.remaining !== 8'd30)
            $display("FAIL load_entry: phase=%0d rem=%0d want 3/30",
                     bus.phase, bus.remaining);
        else passed++;
        bus.wash_Operation = 1'b0;
        step(1);
    endtask

    task automatic test_fault();
        do_reset();
        bus.wash_Operation = 1'b1;
        step(6);
        bus.fault = 1'b1;
        step(1);
        total++;
        if (bus.phase !== 3'd0 || bus.remaining !== 8'd0 ||
            bus.sig_Wash_Completed !== 1'b0)
            $display("FAIL fault_cut: phase=%0d rem=%0d want 0/0",
                     bus.phase, bus.remaining);
        else passed++;
        bus.fault = 1'b0;
        step(1);
        total++;
        if (bus.phase !== 3'd3 || bus.remaining !== 8'd40)
            $display("FAIL fault_reenter: phase=%0d rem=%0d want 3/40",
                     bus.phase, bus.remaining);
        else passed++;
        bus.wash_Operation = 1'b0;
        step(1);
    endtask

    task automatic test_error_reset();
        do_reset();
        bus.wash_Operation = 1'b1;
        bus.rinse_Operation = 1'b1;
        step(1);
        total++;
        if (bus.phase_Error !== 1'b1 || bus.phase !== 3'd0)
            $display("FAIL err_set: err=%b phase=%0d want 1/0",
                     bus.phase_Error, bus.phase);
        else passed++;
        bus.wash_Operation = 1'b0;
        bus.rinse_Operation = 1'b0;
        step(2);
        total++;
        if (bus.phase_Error !== 1'b1)
            $display("FAIL err_sticky: err=%b want 1", bus.phase_Error);
        else passed++;
        bus.heat_Water_Operation = 1'b1;
        step(1);
        total++;
        if (bus.phase !== 3'd2 || bus.remaining !== 8'd90)
            $display("FAIL heat_load: phase=%0d rem=%0d want 2/90",
                     bus.phase, bus.remaining);
        else passed++;
        step(10);
        reset = 1'b1;
        step(1);
        total++;
        if (bus.phase !== 3'd0 || bus.remaining !== 8'd0 ||
            bus.phase_Error !== 1'b0 || bus.sig_Time_Out !== 1'b0)
            $display("FAIL mid_reset: phase=%0d rem=%0d err=%b want 0/0/0",
                     bus.phase, bus.remaining, bus.phase_Error);
        else passed++;
        reset = 1'b0;
        step(1);
        total++;
        if (bus.phase !== 3'd2 || bus.remaining !== 8'd90)
            $display("FAIL post_reset: phase=%0d rem=%0d want 2/90",
                     bus.phase, bus.remaining);
        else passed++;
        bus.heat_Water_Operation = 1'b0;
        step(1);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_wash();
        test_fill_timeout();
        test_lid_pause();
        test_lockout();
        test_load_with_entry();
        test_fault();
        test_error_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cycle_timer.md
CYCLE_TIMER -- requirements
Module: cycle_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000: clock cycles per timer tick (legal range 2..65535).
REQ-002 SHALL have parameter FILL_LIMIT, default 8'd60: fill timeout, in ticks.
REQ-003 SHALL have parameter HEAT_LIMIT, default 8'd90: heat timeout, in ticks.
REQ-004 SHALL have port clock, input, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port program_Select, input, 2: wash program code.
REQ-007 SHALL have port load_Program, input, 1: latch program_Select.
REQ-008 SHALL have ports fill_Water_Operation, heat_Water_Operation, wash_Operation, rinse_Operation and spin_Operation, each input, 1: one-hot controller phase indications.
REQ-009 SHALL have port fault, input, 1: controller in fault state.
REQ-010 SHALL have port sig_Lid_Closed, input, 1: lid sensor; 0 = open.
REQ-011 SHALL have port sig_Time_Out, output, 1: fill or heat limit expired.
REQ-012 SHALL have ports sig_Wash_Completed, sig_Rinse_Completed and sig_Spin_Completed, each output, 1: phase duration elapsed.
REQ-013 SHALL have port paused, output, 1: timed phase frozen by open lid.
REQ-014 SHALL have port phase_Error, output, 1: sticky; more than one phase input seen high.
REQ-015 SHALL have port remaining, output, 8: ticks left in the current phase.
REQ-016 SHALL have port phase, output, 3: 0 NONE, 1 FILL, 2 HEAT, 3 WASH, 4 RINSE, 5 SPIN.

Function
REQ-017 SHALL decode a registered phase each cycle from the inputs:
- exactly one operation input high and fault low -> the matching phase;
- otherwise -> NONE.
REQ-018 SHALL set phase_Error when two or more operation inputs are high in the same cycle; it holds until reset.
REQ-019 SHALL, on the edge at which the decoded phase differs from the registered phase, load remaining with that phase's duration and clear the prescaler to 0.
REQ-020 SHALL use these durations:
- FILL = FILL_LIMIT, HEAT = HEAT_LIMIT, NONE = 0;
- WASH/RINSE/SPIN from the latched program: 0 = 40/20/15, 1 = 20/10/8, 2 = 60/30/25, 3 = 30/20/5.
REQ-021 SHALL run the prescaler from 0 to TICK_DIV-1 and wrap to 0; a tick occurs on the edge where the prescaler equals TICK_DIV-1.
REQ-022 SHALL decrement remaining by 1 on each tick while remaining > 0; remaining saturates at 0 and never wraps.
REQ-023 SHALL, with sig_Lid_Closed = 0 in WASH, RINSE or SPIN, hold both the prescaler and remaining and assert paused; counting resumes from the held values when the lid closes.
REQ-024 SHALL never pause in FILL or HEAT; paused = 0 in every phase other than WASH, RINSE or SPIN.
REQ-025 SHALL drive the status outputs combinationally from registers, held while the condition persists:
- sig_Time_Out = (phase FILL or HEAT) and remaining == 0;
- each Completed output = (its phase) and remaining == 0.
REQ-026 SHALL drop all status outputs in the cycle after the registered phase changes.
REQ-027 SHALL latch program_Select on load_Program only while the registered phase is NONE; a load in any other phase is ignored.
REQ-028 SHALL, when a phase change and a tick coincide, give priority to the load: no decrement on that edge.
REQ-029 SHALL, when load_Program and a phase change coincide, latch the program first, so the new phase uses the new program.
REQ-030 SHALL make latency from phase load to completion exactly duration*TICK_DIV edges, not counting edges held by a pause.

Reset
REQ-031 SHALL, while reset is high at a clock edge, set the following; reset has priority over all other inputs, including mid-phase:
- phase = NONE, remaining = 0, prescaler = 0, program = 0, phase_Error = 0;
- all status outputs = 0.
REQ-032 SHALL, on the first edge after reset deasserts, decode the phase from the inputs as normal; an operation input already high then loads its duration.

Verification (TICK_DIV = 4)
REQ-033 SHALL cover normal wash: program 0 loaded in NONE; wash_Operation held -> sig_Wash_Completed rises exactly 160 edges after the phase load and stays high until wash_Operation falls.
REQ-034 SHALL cover fill timeout: fill_Water_Operation held -> sig_Time_Out = 1 exactly 240 edges after load; remaining = 0.
REQ-035 SHALL cover lid pause: program 1, spin active, sig_Lid_Closed = 0 for 10 cycles mid-phase -> paused = 1 and remaining frozen for those cycles; completion arrives at 32 + 10 edges.
REQ-036 SHALL cover program lockout: load_Program with program 2 during RINSE -> ignored; rinse completes at program-0 timing (80 edges).
REQ-037 SHALL cover a fault cut: fault = 1 during wash -> phase = NONE and outputs 0 next cycle; wash re-entry reloads 40.
REQ-038 SHALL cover error and reset: wash and rinse both high -> phase_Error = 1 and phase = NONE; reset mid-heat -> all outputs 0 and phase_Error cleared.
